side_ch_s_axis_rx: RTL and testbench
====================================

# side_ch_s_axis_rx

Stream receiver for the side channel: it accepts AXI-Stream beats pushed by the PS DMA (PS→PL direction) into an on-chip first-word-fall-through FIFO. It presents the words to side-channel PL logic through a pop interface (`data_to_pl` / `pl_ask_data`). It is the counterpart of the side-channel PL→PS stream master and sits beside it in `side_ch`, sharing the same register-driven length and endless-mode controls.

## Interface
Parameters:
- `C_S_AXIS_TDATA_WIDTH`, 64, stream and FIFO word width.
- `MAX_NUM_DMA_SYMBOL`, 8192 (4096 under `SIDE_CH_LESS_BRAM`), FIFO depth in words.
- `MAX_BIT_NUM_DMA_SYMBOL`, clogb2(MAX_NUM_DMA_SYMBOL)=14, width of count and length fields.

Ports (one clock; reset is asynchronous and active-low):
- `S_AXIS_ACLK` in 1: sole clock.
- `S_AXIS_ARESETN` in 1: async active-low reset. `side_ch` drives it with aresetn & ~slv_reg0[1].
- `s_axis_endless_mode` in 1: 1 = ignore length and TLAST, receive continuously.
- `S_AXIS_NUM_DMA_SYMBOL` in MAX_BIT: words per transfer minus 1.
- `s_axis_state` out 1: 0 = IDLE, 1 = WRITE_FIFO.
- `frame_err` out 1: sticky framing error, cleared only by reset.
- `data_to_pl` out C_S_AXIS_TDATA_WIDTH: FIFO head word.
- `pl_ask_data` in 1: pop request.
- `s_axis_data_count` out MAX_BIT: FIFO occupancy, 0..MAX_NUM_DMA_SYMBOL.
- `emptyn_to_pl` out 1: head word is valid.
- `S_AXIS_TREADY` out 1; `S_AXIS_TDATA` in C_S_AXIS_TDATA_WIDTH; `S_AXIS_TSTRB` in C_S_AXIS_TDATA_WIDTH/8 (ignored); `S_AXIS_TLAST` in 1; `S_AXIS_TVALID` in 1.

## Operation
Reset values: all outputs 0. This includes `data_to_pl`, `s_axis_data_count`, `emptyn_to_pl`, `S_AXIS_TREADY`, `s_axis_state` and `frame_err`. The FIFO is emptied and the beat counter is cleared.

State machine:
- **IDLE**
  - `S_AXIS_TREADY` = 0.
  - When `S_AXIS_TVALID`=1, clear `beat_cnt` and go to WRITE_FIFO. No beat is accepted in the IDLE cycle.
- **WRITE_FIFO**
  - `S_AXIS_TREADY` = ~fifo_full (combinational from registered full).
  - Accept = TVALID & TREADY. Each accept writes TDATA and increments `beat_cnt` (MAX_BIT wide).
- **Exit from WRITE_FIFO, non-endless mode**
  - Return to IDLE on an accept where `beat_cnt` == `S_AXIS_NUM_DMA_SYMBOL`, or on an accept with TLAST=1, whichever comes first.
  - Set `frame_err` if TLAST=1 with `beat_cnt` < NUM, or if `beat_cnt` == NUM with TLAST=0.
- **Exit from WRITE_FIFO, endless mode**
  - Never leave WRITE_FIFO, never set `frame_err`; `beat_cnt` wraps modulo 2^MAX_BIT.
- **Mode change mid-transfer:** `s_axis_endless_mode` is sampled each accept; clearing it mid-transfer applies the length/TLAST exit on the next accept.

FIFO pop interface:
- Pop = `pl_ask_data` & `emptyn_to_pl`.
- A pop request while empty is ignored and causes no underflow.
- Simultaneous push and pop: occupancy is unchanged and both take effect.
- Full: occupancy == MAX_NUM_DMA_SYMBOL, so TREADY = 0. Overflow is structurally impossible.
- Wrap-around: read and write pointers are MAX_BIT-1 bits wide and wrap naturally; occupancy is kept as a separate counter.

## Timing
- Beat accepted at edge k into an empty FIFO: `s_axis_data_count` = 1 after edge k; `emptyn_to_pl` = 1 with the word on `data_to_pl` after edge k+1. This is a one-cycle registered-read latency.
- Pop at edge k: the next word is on `data_to_pl` after edge k. The head register is refilled from the prefetch stage, so back-to-back pops sustain one word per cycle.
- `s_axis_data_count` decrements after the pop edge. The count can therefore lead `emptyn_to_pl` by one cycle when the FIFO goes from empty to non-empty.
- TREADY falls the cycle after the accept that fills the FIFO and rises the cycle after the first pop from full.
- Throughput is one beat per cycle in steady state. There is one idle cycle of TREADY = 0 per transfer, spent in the IDLE→WRITE_FIFO entry.
- Async reset asserted mid-transfer: everything clears immediately. Beats in flight are dropped, and after release the block re-enters IDLE.

## Structure
- Width and depth constants, including the `SIDE_CH_LESS_BRAM` selection, belong in the shared side-channel scale header/package alongside `fpga_scale.v`. State encodings are defined there too.
- One sub-module: `side_ch_rx_fifo`, a synchronous FWFT FIFO.
  - Block-RAM array with registered read plus a head register.
  - Ports: push, din, pop, dout, emptyn, full, count.
- The top level holds only the state machine, `beat_cnt` and `frame_err`.

## Test plan
- **Framed transfer:** NUM=3, endless=0; send 4 beats 0x11..0x44 with TLAST on beat 4. Expect return to IDLE, `frame_err`=0, count=4, and pops yielding 0x11,0x22,0x33,0x44 in order.
- **Fill to full:** depth 8192, no pops; stream 8200 beats in endless mode. Expect TREADY=0 after 8192 accepts and count=8192. After one pop, TREADY=1 the next cycle and exactly one more beat is accepted.
- **Early TLAST:** NUM=7; TLAST on beat 3. Expect IDLE after beat 3, `frame_err`=1, count=3.
- **Missing TLAST:** NUM=1; 2 beats with TLAST=0. Expect IDLE and `frame_err`=1. A third beat is held with TREADY=0 for one cycle, then a new transfer is entered.
- **Simultaneous push and pop:** count=5, continuous push and pop for 100 cycles. Expect count stays 5, data order preserved, no pop accepted while empty.
- **Reset mid-transfer:** reset asserted after 10 of 16 beats. Expect all outputs 0 immediately. After release, a fresh 4-beat transfer is received cleanly.

Source files
------------

// File: rtl/side_ch_s_axis_rx_pkg.sv
// side_ch_s_axis_rx_pkg: shared side-channel scale constants and receiver state encoding.
package side_ch_s_axis_rx_pkg;

    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int SIDE_CH_TDATA_WIDTH = 64;
`ifdef SIDE_CH_LESS_BRAM
    localparam int SIDE_CH_MAX_NUM_DMA_SYMBOL = 4096;
`else
    localparam int SIDE_CH_MAX_NUM_DMA_SYMBOL = 8192;
`endif
    localparam int SIDE_CH_MAX_BIT_NUM_DMA_SYMBOL = clogb2(SIDE_CH_MAX_NUM_DMA_SYMBOL);

    typedef enum logic {
        IDLE       = 1'b0,
        WRITE_FIFO = 1'b1
    } rx_state_t;

endpackage

// File: rtl/side_ch_rx_fifo.sv
// side_ch_rx_fifo: first-word-fall-through FIFO built from a registered-read RAM
// whose read register doubles as the head word.
module side_ch_rx_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8192,
    parameter int CW    = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          emptyn,
    output logic          full,
    output logic [CW-1:0] count
);
    localparam int AW = CW - 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          fetch;
    logic [CW-1:0] mem_cnt;
    logic [CW-1:0] count_next;

    // Words still in RAM exclude the one already presented on dout.
    assign do_pop     = pop & emptyn;
    assign mem_cnt    = count - CW'(emptyn);
    assign fetch      = (do_pop | ~emptyn) & (mem_cnt != '0);
    assign count_next = count + CW'(push) - CW'(do_pop);

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            emptyn <= 1'b0;
            dout   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (fetch) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            emptyn <= fetch | (emptyn & ~do_pop);
            count  <= count_next;
            full   <= count_next == CW'(DEPTH);
        end
    end

endmodule

// File: rtl/side_ch_s_axis_rx.sv
// side_ch_s_axis_rx: AXI-Stream slave that frames PS DMA transfers into a FWFT FIFO
// drained by side-channel PL logic.
module side_ch_s_axis_rx
    import side_ch_s_axis_rx_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH   = SIDE_CH_TDATA_WIDTH,
    parameter int MAX_NUM_DMA_SYMBOL     = SIDE_CH_MAX_NUM_DMA_SYMBOL,
    parameter int MAX_BIT_NUM_DMA_SYMBOL = SIDE_CH_MAX_BIT_NUM_DMA_SYMBOL
) (
    input  logic                                S_AXIS_ACLK,
    input  logic                                S_AXIS_ARESETN,
    input  logic                                s_axis_endless_mode,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   S_AXIS_NUM_DMA_SYMBOL,
    output logic                                s_axis_state,
    output logic                                frame_err,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]     data_to_pl,
    input  logic                                pl_ask_data,
    output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   s_axis_data_count,
    output logic                                emptyn_to_pl,
    output logic                                S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
    input  logic                                S_AXIS_TLAST,
    input  logic                                S_AXIS_TVALID
);
    rx_state_t                         state;
    logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] beat_cnt;
    logic                              fifo_full;
    logic                              accept;
    logic                              at_end;
    logic                              unused_tstrb;

    assign unused_tstrb  = ^S_AXIS_TSTRB;
    assign s_axis_state  = state;
    assign S_AXIS_TREADY = (state == WRITE_FIFO) & ~fifo_full;
    assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;
    assign at_end        = beat_cnt == S_AXIS_NUM_DMA_SYMBOL;

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            frame_err <= 1'b0;
        end else if (state == IDLE) begin
            if (S_AXIS_TVALID) begin
                beat_cnt <= '0;
                state    <= WRITE_FIFO;
            end
        end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            // Endless mode is sampled per beat, so clearing it re-arms framing on the next accept.
            if (!s_axis_endless_mode) begin
                if (S_AXIS_TLAST || at_end)
                    state <= IDLE;
                if ((S_AXIS_TLAST && beat_cnt < S_AXIS_NUM_DMA_SYMBOL) || (at_end && !S_AXIS_TLAST))
                    frame_err <= 1'b1;
            end
        end
    end

    side_ch_rx_fifo #(
        .W     (C_S_AXIS_TDATA_WIDTH),
        .DEPTH (MAX_NUM_DMA_SYMBOL),
        .CW    (MAX_BIT_NUM_DMA_SYMBOL)
    ) u_fifo (
        .clk    (S_AXIS_ACLK),
        .rst_n  (S_AXIS_ARESETN),
        .push   (accept),
        .din    (S_AXIS_TDATA),
        .pop    (pl_ask_data),
        .dout   (data_to_pl),
        .emptyn (emptyn_to_pl),
        .full   (fifo_full),
        .count  (s_axis_data_count)
    );

endmodule

// File: tb/tb_side_ch_s_axis_rx.sv
// tb_side_ch_s_axis_rx: randomized and directed bench for the side-channel stream receiver,
// checked against a transfer-level queue model.
module tb_side_ch_s_axis_rx;
    localparam int W     = 64;
    localparam int DEPTH = 8192;
    localparam int MB    = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          endless = 1'b0;
    logic [MB-1:0] num = '0;
    logic          state;
    logic          frame_err;
    logic [W-1:0]  data;
    logic          ask = 1'b0;
    logic [MB-1:0] count;
    logic          emptyn;
    logic          tready;
    logic [W-1:0]  tdata = '0;
    logic [W/8-1:0] tstrb = '1;
    logic          tlast = 1'b0;
    logic          tvalid = 1'b0;

    side_ch_s_axis_rx dut (
        .S_AXIS_ACLK           (clk),
        .S_AXIS_ARESETN        (rst_n),
        .s_axis_endless_mode   (endless),
        .S_AXIS_NUM_DMA_SYMBOL (num),
        .s_axis_state          (state),
        .frame_err             (frame_err),
        .data_to_pl            (data),
        .pl_ask_data           (ask),
        .s_axis_data_count     (count),
        .emptyn_to_pl          (emptyn),
        .S_AXIS_TREADY         (tready),
        .S_AXIS_TDATA          (tdata),
        .S_AXIS_TSTRB          (tstrb),
        .S_AXIS_TLAST          (tlast),
        .S_AXIS_TVALID         (tvalid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int acc_total = 0;
    logic [W-1:0] q[$];
    bit m_busy;
    bit m_err;
    int m_beat;

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic clear_model();
        q.delete();
        m_busy = 0;
        m_err = 0;
        m_beat = 0;
    endtask

    // One clock: predict handshake from the model, advance, then compare all observable state.
    task automatic cyc();
        bit exp_rdy, acc, pop, last_beat;
        exp_rdy = m_busy && (q.size() < DEPTH);
        checks++;
        if (tready !== exp_rdy) begin
            errors++;
            $display("FAIL tready act=%0b exp=%0b t=%0t", tready, exp_rdy, $time);
        end
        pop = ask && emptyn;
        if (emptyn) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL emptyn_on_empty act=1 exp=0 t=%0t", $time);
            end else if (data !== q[0]) begin
                errors++;
                $display("FAIL head_data act=%h exp=%h t=%0t", data, q[0], $time);
            end
        end
        acc = tvalid && exp_rdy;
        @(posedge clk);
        #1;
        if (pop && q.size() > 0) void'(q.pop_front());
        if (acc) begin
            q.push_back(tdata);
            acc_total++;
            if (!endless) begin
                last_beat = (m_beat == int'(num));
                if ((tlast && m_beat < int'(num)) || (last_beat && !tlast)) m_err = 1;
                if (tlast || last_beat) m_busy = 0;
            end
            m_beat = (m_beat + 1) % (1 << MB);
        end else if (!m_busy && tvalid) begin
            m_busy = 1;
            m_beat = 0;
        end
        checks++;
        if (count !== MB'(q.size())) begin
            errors++;
            $display("FAIL count act=%0d exp=%0d t=%0t", count, q.size(), $time);
        end
        checks++;
        if (state !== m_busy) begin
            errors++;
            $display("FAIL state act=%0b exp=%0b t=%0t", state, m_busy, $time);
        end
        checks++;
        if (frame_err !== m_err) begin
            errors++;
            $display("FAIL frame_err act=%0b exp=%0b t=%0t", frame_err, m_err, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tvalid = 1'b0;
        tlast = 1'b0;
        ask = 1'b0;
        endless = 1'b0;
        num = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
    endtask

    // Holds one beat on the bus until accepted; leaves TVALID high for back-to-back sends.
    task automatic send(input logic [W-1:0] d, input bit last);
        bit took;
        tdata = d;
        tlast = last;
        tvalid = 1'b1;
        took = 0;
        for (int t = 0; t < 20 && !took; t++) begin
            took = tready;
            cyc();
        end
        if (!took) begin
            checks++;
            errors++;
            $display("FAIL send_timeout act=no_accept exp=accept data=%h", d);
        end
    endtask

    task automatic expect_pops(input logic [W-1:0] exp_words[4]);
        for (int i = 0; i < 4; i++) begin
            for (int t = 0; t < 5 && !emptyn; t++) cyc();
            checks++;
            if (!emptyn || data !== exp_words[i]) begin
                errors++;
                $display("FAIL pop_%0d act=%h/%0b exp=%h", i, data, emptyn, exp_words[i]);
            end
            ask = 1'b1;
            cyc();
            ask = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, frame_err, data, count, emptyn, tready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs act=%b/%b/%h/%0d/%b/%b exp=all_zero",
                     state, frame_err, data, count, emptyn, tready);
        end
        do_reset();
    endtask

    task automatic test_framed();
        logic [W-1:0] w[4];
        w = '{64'h11, 64'h22, 64'h33, 64'h44};
        do_reset();
        num = 3;
        for (int i = 0; i < 4; i++) send(w[i], i == 3);
        tvalid = 1'b0;
        tlast = 1'b0;
        cyc();
        checks++;
        if (state !== 1'b0 || frame_err !== 1'b0 || count !== 4) begin
            errors++;
            $display("FAIL framed_end act=%b/%b/%0d exp=0/0/4", state, frame_err, count);
        end
        expect_pops(w);
    endtask

    task automatic test_early_tlast();
        do_reset();
        num = 7;
        for (int i = 0; i < 3; i++) send(rnd64(), i == 2);
        tvalid = 1'b0;
        tlast = 1'b0;
        checks++;
        if (state !== 1'b0 || frame_err !== 1'b1 || count !== 3) begin
            errors++;
            $display("FAIL early_tlast act=%b/%b/%0d exp=0/1/3", state, frame_err, count);
        end
        cyc();
    endtask

    task automatic test_missing_tlast();
        do_reset();
        num = 1;
        send(rnd64(), 0);
        send(rnd64(), 0);
        checks++;
        if (state !== 1'b0 || frame_err !== 1'b1 || tready !== 1'b0) begin
            errors++;
            $display("FAIL missing_tlast act=%b/%b/%b exp=0/1/0", state, frame_err, tready);
        end
        tdata = rnd64();
        cyc();
        checks++;
        if (state !== 1'b1 || tready !== 1'b1) begin
            errors++;
            $display("FAIL missing_tlast_reenter act=%b/%b exp=1/1", state, tready);
        end
        send(tdata, 0);
        tvalid = 1'b0;
        cyc();
    endtask

    task automatic test_fill_full();
        do_reset();
        endless = 1'b1;
        acc_total = 0;
        tvalid = 1'b1;
        for (int i = 0; i < DEPTH + 8; i++) begin
            tdata = rnd64();
            cyc();
        end
        checks++;
        if (acc_total != DEPTH || count !== MB'(DEPTH) || tready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full act=%0d/%0d/%b exp=%0d/%0d/0", acc_total, count, tready, DEPTH, DEPTH);
        end
        ask = 1'b1;
        cyc();
        ask = 1'b0;
        checks++;
        if (tready !== 1'b1) begin
            errors++;
            $display("FAIL full_reopen act=%b exp=1", tready);
        end
        for (int i = 0; i < 4; i++) cyc();
        checks++;
        if (acc_total != DEPTH + 1 || tready !== 1'b0 || count !== MB'(DEPTH)) begin
            errors++;
            $display("FAIL full_one_more act=%0d/%b/%0d exp=%0d/0/%0d", acc_total, tready, count, DEPTH + 1, DEPTH);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        endless = 1'b1;
        tvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tdata = rnd64();
            cyc();
        end
        cyc();
        checks++;
        if (count !== 6) begin
            errors++;
            $display("FAIL prefill_count act=%0d exp=6", count);
        end
        tvalid = 1'b0;
        ask = 1'b1;
        cyc();
        ask = 1'b0;
        tvalid = 1'b1;
        ask = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tdata = rnd64();
            cyc();
            checks++;
            if (count !== 5) begin
                errors++;
                $display("FAIL push_pop_count act=%0d exp=5 iter=%0d", count, i);
            end
        end
        tvalid = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        ask = 1'b0;
        checks++;
        if (count !== 0 || emptyn !== 1'b0) begin
            errors++;
            $display("FAIL drain act=%0d/%b exp=0/0", count, emptyn);
        end
    endtask

    task automatic test_random();
        do_reset();
        num = MB'($urandom_range(0, 5));
        for (int i = 0; i < 600; i++) begin
            tvalid = ($urandom_range(0, 3) != 0);
            tlast = ($urandom_range(0, 7) == 0);
            tdata = rnd64();
            ask = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) endless = ~endless;
            cyc();
        end
        tvalid = 1'b0;
        ask = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w[4];
        w = '{64'hA1, 64'hB2, 64'hC3, 64'hD4};
        do_reset();
        num = 15;
        for (int i = 0; i < 10; i++) send(rnd64(), 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, frame_err, data, count, emptyn, tready} !== '0) begin
            errors++;
            $display("FAIL reset_mid act=%b/%b/%h/%0d/%b/%b exp=all_zero",
                     state, frame_err, data, count, emptyn, tready);
        end
        do_reset();
        num = 3;
        for (int i = 0; i < 4; i++) send(w[i], i == 3);
        tvalid = 1'b0;
        tlast = 1'b0;
        cyc();
        checks++;
        if (state !== 1'b0 || frame_err !== 1'b0 || count !== 4) begin
            errors++;
            $display("FAIL reset_mid_fresh act=%b/%b/%0d exp=0/0/4", state, frame_err, count);
        end
        expect_pops(w);
    endtask

    initial begin
        clear_model();
        test_reset();
        test_framed();
        test_early_tlast();
        test_missing_tlast();
        test_fill_full();
        test_push_pop();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
